// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and types for the pipeline control sequencer.
//   STALL_* : per-stage stall vectors (bit0=PC .. bit5=WB)
//   ctrl_state_e : sequencer states
//   RstEnable : active level of the block reset
package pipe_ctrl_pkg;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic RstEnable = 1'b0;

  typedef enum logic [1:0] {
    CTRL_RUN        = 2'd0,
    CTRL_FLUSH_PEND = 2'd1,
    CTRL_FLUSH      = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_enc.sv
// stall_enc: priority encoder turning stage stall requests into a stall vector.
//   stallreq_id_i  : ID load-use stall request
//   stallreq_ex_i  : EX multi-cycle busy
//   stallreq_mem_i : MEM access outstanding
//   stall_o        : 6-bit stall vector, priority MEM > EX > ID
module stall_enc
  import pipe_ctrl_pkg::*;
(
  input  logic       stallreq_id_i,
  input  logic       stallreq_ex_i,
  input  logic       stallreq_mem_i,
  output logic [5:0] stall_o
);

  always_comb begin
    stall_o = STALL_NONE;
    if (stallreq_mem_i)      stall_o = STALL_MEM;
    else if (stallreq_ex_i)  stall_o = STALL_EX;
    else if (stallreq_id_i)  stall_o = STALL_ID;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush sequencer with stall statistics.
//   clk, rst (sync, active-low)
//   stallreq_{id,ex,mem}_i : stage stall requests
//   flushreq_i, flush_pc_i : flush request and restart address
//   stall_o          : combinational per-stage stall vector
//   flush_o, new_pc_o: registered one-cycle flush strobe and reload PC
//   stall_timeout_o  : sticky consecutive-stall watchdog flag
//   stall_cycles_o   : total stalled cycles (wrapping)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_STALL = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              stallreq_mem_i,
  input  logic              flushreq_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              stall_timeout_o,
  output logic [31:0]       stall_cycles_o
);

  ctrl_state_e       state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              flush_q;
  logic              timeout_q;
  logic [31:0]       stall_cycles_q, stall_cycles_d;
  logic [7:0]        consec_q, consec_d;
  logic [5:0]        enc_stall;
  logic              stalled;

  stall_enc u_stall_enc (
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .stallreq_mem_i (stallreq_mem_i),
    .stall_o        (enc_stall)
  );

  // Requests during FLUSH come from stages being discarded, so they are masked.
  always_comb begin
    stall_o = enc_stall;
    if (rst == RstEnable || state_q == CTRL_FLUSH) stall_o = STALL_NONE;
  end

  assign stalled = (stall_o != STALL_NONE);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    consec_d       = '0;
    if (stalled) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
      consec_d       = (consec_q == 8'hFF) ? consec_q : consec_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q        <= CTRL_RUN;
      pc_q           <= '0;
      flush_q        <= 1'b0;
      timeout_q      <= 1'b0;
      stall_cycles_q <= '0;
      consec_q       <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      consec_q       <= consec_d;
      if (consec_d == 8'(MAX_STALL)) timeout_q <= 1'b1;
      flush_q <= 1'b0;
      case (state_q)
        CTRL_RUN, CTRL_FLUSH: begin
          state_q <= CTRL_RUN;
          if (flushreq_i) begin
            pc_q <= flush_pc_i;
            if (stallreq_mem_i) begin
              state_q <= CTRL_FLUSH_PEND;
            end else begin
              state_q <= CTRL_FLUSH;
              flush_q <= 1'b1;
            end
          end
        end
        CTRL_FLUSH_PEND: begin
          // Latest request wins while waiting for MEM to drain.
          if (flushreq_i) pc_q <= flush_pc_i;
          if (!stallreq_mem_i) begin
            state_q <= CTRL_FLUSH;
            flush_q <= 1'b1;
          end
        end
        default: state_q <= CTRL_RUN;
      endcase
    end
  end

  assign flush_o         = flush_q;
  assign new_pc_o        = pc_q;
  assign stall_timeout_o = timeout_q;
  assign stall_cycles_o  = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic        flushreq_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_timeout_o;
  logic [31:0] stall_cycles_o;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_ctrl #(.ADDR_W(32), .MAX_STALL(15)) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_id_i   (stallreq_id_i),
    .stallreq_ex_i   (stallreq_ex_i),
    .stallreq_mem_i  (stallreq_mem_i),
    .flushreq_i      (flushreq_i),
    .flush_pc_i      (flush_pc_i),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .new_pc_o        (new_pc_o),
    .stall_timeout_o (stall_timeout_o),
    .stall_cycles_o  (stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, id, ex, mem, fr;
    logic [31:0] pc;
    logic [5:0]  exp_stall;
    logic        exp_flush;
    logic [31:0] exp_pc;
    logic [31:0] exp_cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic i, input logic e, input logic m,
                     input logic f, input logic [31:0] p, input logic [5:0] es,
                     input logic ef, input logic [31:0] ep, input logic [31:0] ec);
    vec_t v;
    v.rst = r; v.id = i; v.ex = e; v.mem = m; v.fr = f; v.pc = p;
    v.exp_stall = es; v.exp_flush = ef; v.exp_pc = ep; v.exp_cyc = ec;
    vecs.push_back(v);
  endtask

  // Drive inputs mid-cycle; combinational stall_o is checked before the edge.
  task automatic drive(input logic r, input logic i, input logic e, input logic m,
                       input logic f, input logic [31:0] p);
    @(negedge clk);
    rst = r; stallreq_id_i = i; stallreq_ex_i = e; stallreq_mem_i = m;
    flushreq_i = f; flush_pc_i = p;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stallreq_id_i = 0; stallreq_ex_i = 0; stallreq_mem_i = 0;
    flushreq_i = 0; flush_pc_i = '0;

    //   rst id ex mem fr  pc          stall      flush pc          cycles
    add(0, 1, 1, 1, 1, 32'hAAA, 6'b000000, 0, 32'h0,   0);
    add(0, 1, 1, 1, 1, 32'hAAA, 6'b000000, 0, 32'h0,   0);
    add(0, 1, 1, 1, 1, 32'hAAA, 6'b000000, 0, 32'h0,   0);
    add(1, 1, 1, 1, 0, 32'h0,   6'b011111, 0, 32'h0,   1);
    add(1, 1, 1, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   2);
    add(1, 1, 0, 0, 0, 32'h0,   6'b000111, 0, 32'h0,   3);
    add(1, 1, 0, 0, 0, 32'h0,   6'b000111, 0, 32'h0,   4);
    add(1, 0, 1, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   5);
    add(1, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   5);
    add(1, 0, 0, 0, 1, 32'h100, 6'b000000, 1, 32'h100, 5);
    add(1, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h100, 5);
    add(1, 1, 0, 0, 1, 32'h180, 6'b000111, 1, 32'h180, 6);
    add(1, 1, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h180, 6);
    add(1, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h180, 6);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rst, vecs[k].id, vecs[k].ex, vecs[k].mem, vecs[k].fr, vecs[k].pc);
      chk($sformatf("vec%0d stall", k), 64'(stall_o), 64'(vecs[k].exp_stall));
      edge_wait();
      chk($sformatf("vec%0d flush", k), 64'(flush_o), 64'(vecs[k].exp_flush));
      chk($sformatf("vec%0d new_pc", k), 64'(new_pc_o), 64'(vecs[k].exp_pc));
      chk($sformatf("vec%0d cycles", k), 64'(stall_cycles_o), 64'(vecs[k].exp_cyc));
      chk($sformatf("vec%0d timeout", k), 64'(stall_timeout_o), 64'd0);
    end

    // Deferred flush: MEM busy 4 cycles, two flush requests, latest PC wins.
    drive(1, 0, 0, 1, 1, 32'h200);
    chk("pend c1 stall", 64'(stall_o), 64'h1F);
    edge_wait(); chk("pend c1 flush", 64'(flush_o), 64'd0);
    drive(1, 0, 0, 1, 1, 32'h300);
    chk("pend c2 stall", 64'(stall_o), 64'h1F);
    edge_wait(); chk("pend c2 flush", 64'(flush_o), 64'd0);
    for (int c = 3; c <= 4; c++) begin
      drive(1, 0, 0, 1, 0, 32'h0);
      chk($sformatf("pend c%0d stall", c), 64'(stall_o), 64'h1F);
      edge_wait(); chk($sformatf("pend c%0d flush", c), 64'(flush_o), 64'd0);
    end
    drive(1, 0, 0, 0, 0, 32'h0);
    chk("pend c5 stall", 64'(stall_o), 64'd0);
    edge_wait();
    chk("pend c5 flush", 64'(flush_o), 64'd1);
    chk("pend c5 new_pc", 64'(new_pc_o), 64'h300);
    drive(1, 1, 0, 0, 0, 32'h0);
    chk("pend flush-cycle stall masked", 64'(stall_o), 64'd0);
    edge_wait();
    chk("pend c6 flush", 64'(flush_o), 64'd0);
    chk("pend cycles", 64'(stall_cycles_o), 64'd10);

    // Reset while a flush is pending: it must be abandoned.
    drive(1, 0, 0, 1, 1, 32'h400);
    edge_wait(); chk("rstpend enter flush", 64'(flush_o), 64'd0);
    drive(0, 0, 0, 1, 0, 32'h0);
    chk("rstpend stall in reset", 64'(stall_o), 64'd0);
    edge_wait();
    chk("rstpend pc cleared", 64'(new_pc_o), 64'd0);
    chk("rstpend cycles cleared", 64'(stall_cycles_o), 64'd0);
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 0, 0, 0, 32'h0);
      edge_wait();
      chk($sformatf("rstpend idle%0d flush", c), 64'(flush_o), 64'd0);
    end
    drive(1, 0, 0, 0, 1, 32'h500);
    edge_wait();
    chk("rstpend run flush", 64'(flush_o), 64'd1);
    chk("rstpend run pc", 64'(new_pc_o), 64'h500);

    // Watchdog: 15 consecutive EX stalls from a clean reset.
    drive(0, 0, 0, 0, 0, 32'h0);
    edge_wait();
    for (int c = 1; c <= 15; c++) begin
      drive(1, 0, 1, 0, 0, 32'h0);
      edge_wait();
      if (c >= 14)
        chk($sformatf("wd cycle%0d timeout", c), 64'(stall_timeout_o), (c == 15) ? 64'd1 : 64'd0);
    end
    chk("wd cycles", 64'(stall_cycles_o), 64'd15);
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 0, 0, 0, 32'h0);
      edge_wait();
      chk($sformatf("wd sticky%0d", c), 64'(stall_timeout_o), 64'd1);
    end
    drive(0, 0, 0, 0, 0, 32'h0);
    edge_wait();
    chk("wd cleared by reset", 64'(stall_timeout_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
